// File: rtl/io_debounce_bit.sv
// io_debounce_bit: one input bit through a 2-flop synchronizer, a stable-count
// debounce filter and a registered rising-edge pulse.
module io_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // An accepted change always has sync2 != stable, so sync2 alone marks a 0->1 acceptance
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            rise   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == stable)
                cnt <= '0;
            else if (cnt == LAST) begin
                stable <= sync2;
                rise   <= sync2;
                cnt    <= '0;
            end else
                cnt <= cnt + CNT_W'(1);
        end
endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronizes and debounces the raw board inputs feeding
// core.io_input_bus, with a one-cycle rising-edge pulse per bit.
module io_input_conditioner #(
    parameter int IO_INPUT_BUS_LEN = 14,
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int CNT_W            = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [IO_INPUT_BUS_LEN-1:0] raw_in,
    output logic [IO_INPUT_BUS_LEN-1:0] io_input_bus,
    output logic [IO_INPUT_BUS_LEN-1:0] rise_pulse
);
    genvar i;
    generate
        for (i = 0; i < IO_INPUT_BUS_LEN; i++) begin : g_bit
            io_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_bit (
                .clock (clock),
                .reset (reset),
                .raw   (raw_in[i]),
                .stable(io_input_bus[i]),
                .rise  (rise_pulse[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: directed vectors for the input conditioner at
// DEBOUNCE_CYCLES=4, plus reset and DEBOUNCE_CYCLES=1 sequences.
module tb_io_input_conditioner;
    typedef struct {
        logic [13:0] raw;
        logic [13:0] bus;
        logic [13:0] rise;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] raw_in = '0;
    logic [13:0] raw1 = '0;
    logic [13:0] io_input_bus, rise_pulse;
    logic [13:0] bus1, rise1;
    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    io_input_conditioner #(.IO_INPUT_BUS_LEN(14), .DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .raw_in(raw_in),
        .io_input_bus(io_input_bus), .rise_pulse(rise_pulse)
    );

    io_input_conditioner #(.IO_INPUT_BUS_LEN(14), .DEBOUNCE_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .raw_in(raw1),
        .io_input_bus(bus1), .rise_pulse(rise1)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [13:0] raw, input logic [13:0] bus, input logic [13:0] rise, input int n);
        for (int k = 0; k < n; k++) vecs.push_back('{raw, bus, rise});
    endtask

    initial begin
        // clean rise on bit 0: accepted on the 6th edge counting the sampling edge
        add(14'h0001, 14'h0000, 14'h0000, 5);
        add(14'h0001, 14'h0001, 14'h0001, 1);
        add(14'h0001, 14'h0001, 14'h0000, 2);
        // 3-cycle glitch on bit 3 is rejected
        add(14'h0009, 14'h0001, 14'h0000, 3);
        add(14'h0001, 14'h0001, 14'h0000, 6);
        // 4-cycle pulse on bit 4 is the minimum accepted width; its fall gives no pulse
        add(14'h0011, 14'h0001, 14'h0000, 4);
        add(14'h0001, 14'h0001, 14'h0000, 1);
        add(14'h0001, 14'h0011, 14'h0010, 1);
        add(14'h0001, 14'h0011, 14'h0000, 3);
        add(14'h0001, 14'h0001, 14'h0000, 2);
        // bounce on bit 5: 1,0,1,1,0 then held high
        add(14'h0021, 14'h0001, 14'h0000, 1);
        add(14'h0001, 14'h0001, 14'h0000, 1);
        add(14'h0021, 14'h0001, 14'h0000, 2);
        add(14'h0001, 14'h0001, 14'h0000, 1);
        add(14'h0021, 14'h0001, 14'h0000, 5);
        add(14'h0021, 14'h0021, 14'h0020, 1);
        add(14'h0021, 14'h0021, 14'h0000, 2);
        // simultaneous falls of bits 0 and 5
        add(14'h0000, 14'h0021, 14'h0000, 5);
        add(14'h0000, 14'h0000, 14'h0000, 2);
        // all bits rise together
        add(14'h3FFF, 14'h0000, 14'h0000, 5);
        add(14'h3FFF, 14'h3FFF, 14'h3FFF, 1);
        add(14'h3FFF, 14'h3FFF, 14'h0000, 1);

        tick();
        tick();
        check("reset_bus", io_input_bus, 14'h0000);
        check("reset_rise", rise_pulse, 14'h0000);
        check("reset_bus1", bus1, 14'h0000);
        reset = 1'b1;

        foreach (vecs[n]) begin
            raw_in = vecs[n].raw;
            tick();
            check($sformatf("vec%0d_bus", n), io_input_bus, vecs[n].bus);
            check($sformatf("vec%0d_rise", n), rise_pulse, vecs[n].rise);
        end
        check("idle_bus1", bus1, 14'h0000);

        // async reset with outputs high, input held high through reset
        reset = 1'b0;
        #1;
        check("async_reset_bus", io_input_bus, 14'h0000);
        check("async_reset_rise", rise_pulse, 14'h0000);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("held_pre_bus", io_input_bus, 14'h0000);
        tick();
        check("held_acc_bus", io_input_bus, 14'h3FFF);
        check("held_acc_rise", rise_pulse, 14'h3FFF);
        tick();
        check("held_post_rise", rise_pulse, 14'h0000);

        raw_in = 14'h0000;
        repeat (6) tick();
        check("clear_bus", io_input_bus, 14'h0000);
        check("clear_rise", rise_pulse, 14'h0000);

        // reset during the 3rd counting cycle discards the count
        raw_in = 14'h0001;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check("midcount_bus", io_input_bus, 14'h0000);
        check("midcount_rise", rise_pulse, 14'h0000);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("midcount_pre_bus", io_input_bus, 14'h0000);
        tick();
        check("midcount_acc_bus", io_input_bus, 14'h0001);
        check("midcount_acc_rise", rise_pulse, 14'h0001);

        // DEBOUNCE_CYCLES = 1: 3-edge latency
        raw1 = 14'h3FFF;
        tick();
        tick();
        check("d1_pre_bus", bus1, 14'h0000);
        tick();
        check("d1_acc_bus", bus1, 14'h3FFF);
        check("d1_acc_rise", rise1, 14'h3FFF);
        tick();
        check("d1_post_rise", rise1, 14'h0000);
        check("d1_post_bus", bus1, 14'h3FFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Conditions the raw board inputs (switches and push-buttons) before they reach the core's `io_input_bus` port, so the memory-mapped IO read path sees clean, metastability-free levels. Each bit passes through a 2-flop synchronizer and then a per-bit debounce filter. The block also produces a one-cycle rising-edge pulse per bit, for button-press detection. It sits between the top-level pins and `core`, in the same clock domain as `core`.

## Interface
Parameters:
- `IO_INPUT_BUS_LEN`, 14: number of input bits; must match `core`.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a level change is accepted. Legal range ≥ 1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: width of the per-bit counter (derived).

Ports:
- `clock`: input, 1 bit. Single system clock, rising-edge.
- `reset`: input, 1 bit. Asynchronous, active-low. 0 resets the block immediately, independent of `clock`.
- `raw_in`: input, `IO_INPUT_BUS_LEN` bits. Asynchronous pin levels.
- `io_input_bus`: output, `IO_INPUT_BUS_LEN` bits. Debounced stable levels; drives `core.io_input_bus`.
- `rise_pulse`: output, `IO_INPUT_BUS_LEN` bits. Bit i is high for exactly one cycle when `io_input_bus[i]` goes 0→1.

## Operation
- Each bit is independent; the same logic is replicated per bit.
- Synchronizer: `sync1 <= raw_in`, then `sync2 <= sync1`. Only `sync2` is used downstream.
- Filter state per bit: `stable` (drives `io_input_bus`) and `cnt` (`CNT_W` bits).
- Filter rule, evaluated every clock edge:
  - If `sync2 == stable`: `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- The counter never wraps. It is bounded by DEBOUNCE_CYCLES-1 and clears on any return to match.
- A mismatch that disappears before acceptance is a glitch. The counter restarts from 0, and a later mismatch must again persist the full DEBOUNCE_CYCLES.
- `rise_pulse[i]` is a register, set to 1 on the same edge that `stable[i]` goes 0→1, and cleared to 0 on every other edge.
- There is no falling-edge pulse. A 1→0 acceptance updates `stable` only.
- Simultaneous changes on several bits are filtered independently. Multiple `rise_pulse` bits may be high in the same cycle.
- `DEBOUNCE_CYCLES = 1`: any sync2 mismatch is accepted on its first edge. The filter is effectively a third flop.

## Timing
- Reset (`reset == 0`): `sync1`, `sync2`, `stable`, `cnt`, `io_input_bus`, and `rise_pulse` all go to 0 asynchronously.
  - Reset is released synchronously to `clock` at the top level.
  - An input held high through reset appears on `io_input_bus` DEBOUNCE_CYCLES+2 edges after release, with one `rise_pulse`.
- Reset asserted mid-count: the count is discarded and the output returns to 0 immediately. No pulse is emitted.
- Latency: a clean level change sampled on edge k into `sync1` updates `io_input_bus` on edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges in total. `rise_pulse` is high in the cycle following that edge.
- Output registers only. There are no combinational paths from `raw_in` to any output.
- Minimum accepted pulse width at `sync2`: DEBOUNCE_CYCLES cycles. Shorter pulses are rejected.

## Structure
- No shared package is needed. All constants are module parameters. `IO_INPUT_BUS_LEN` is passed from the same top-level value given to `core`.
- One sub-module, `io_debounce_bit`, holds the synchronizer, counter, stable flop and pulse flop for one bit. The top instantiates it `IO_INPUT_BUS_LEN` times with a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` unless stated.
- **Clean rise:** after reset release, `raw_in[0]` 0→1 and held. `io_input_bus[0]` becomes 1 exactly 6 edges after the first sampling edge. `rise_pulse[0]` is high for exactly 1 cycle; all other bits stay 0.
- **Glitch rejection:** `raw_in[3]` high for 3 cycles, then low. `io_input_bus[3]` and `rise_pulse[3]` stay 0 throughout. The internal count returns to 0.
- **Bounce:** `raw_in[5]` pattern 1,0,1,1,0,1,1,1,1 then held high. Exactly one acceptance, 6 edges after the final transition to held 1. Exactly one `rise_pulse[5]`.
- **Fall:** `io_input_bus[2] = 1` and stable, then `raw_in[2]` 1→0. `io_input_bus[2]` goes 0 after 6 edges, with no `rise_pulse`.
- **Reset mid-count:** assert `reset = 0` on the 3rd counting cycle of a rise. All outputs are 0 immediately, without waiting for a clock edge. After release with the input held high, acceptance occurs after a full 6 edges.
- **Multi-bit and minimum setting:** `raw_in = 14'h3FFF` in one cycle gives `rise_pulse = 14'h3FFF` for one cycle. Repeating with `DEBOUNCE_CYCLES = 1` gives a latency of 3 edges.
